// File: rtl/dbus_ram_responder_pkg.sv
// rtl/dbus_ram_responder_pkg.sv - shared data-bus types, responder FSM state and byte-merge helper
package dbus_ram_responder_pkg;

   typedef logic [63:0] addr_t;
   typedef logic [63:0] word_t;
   typedef logic [7:0]  strobe_t;
   typedef logic [2:0]  msize_t;

   typedef struct packed {
      logic    valid;
      addr_t   addr;
      msize_t  size;
      strobe_t strobe;
      word_t   data;
   } dbus_req_t;

   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } dbus_ram_state_t;

   localparam int DBUS_RAM_DEFAULT_DEPTH = 4096;

   // Replace the byte lanes of old_w selected by strb with the same lanes of new_w.
   function automatic word_t byte_merge(input word_t old_w, input word_t new_w, input strobe_t strb);
      word_t r;
      r = old_w;
      for (int i = 0; i < 8; i++) begin
         if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dbus_ram_responder_array.sv
// rtl/dbus_ram_responder_array.sv - single-port word RAM, combinational read, byte-masked clocked write
module dbus_ram_array
   import dbus_ram_responder_pkg::*;
#(
   parameter  int DEPTH_WORDS = DBUS_RAM_DEFAULT_DEPTH,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] idx_i,
   output word_t            rdata_o,
   input  logic             we_i,
   input  strobe_t          strobe_i,
   input  word_t            wdata_i
);

   word_t mem_q [DEPTH_WORDS];

   assign rdata_o = mem_q[idx_i];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[idx_i] <= byte_merge(mem_q[idx_i], wdata_i, strobe_i);
   end

endmodule

// File: rtl/dbus_ram_responder.sv
// rtl/dbus_ram_responder.sv - data-bus RAM responder with fixed latency; DBUS_RAM_RANGE_CHECK_EN adds err
module dbus_ram_responder
   import dbus_ram_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = DBUS_RAM_DEFAULT_DEPTH,
   parameter int LATENCY     = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp
`ifdef DBUS_RAM_RANGE_CHECK_EN
   ,
   output logic       err
`endif
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dbus_ram_state_t  state_q;
   logic [CNT_W-1:0] cnt_q;
   addr_t            addr_q;
   msize_t           size_q;
   strobe_t          strobe_q;
   word_t            data_q;
   dbus_resp_t       resp_q;

   logic [IDX_W-1:0] arr_idx;
   word_t            rdata;
   word_t            resp_data;
   logic             enter_resp;
   logic             rd_oor;
   logic             lat_oor;
   logic             we;
   logic             unused_bits;

   // With LATENCY==1 the read happens on the accept edge, before addr_q holds the address.
   assign arr_idx = (state_q == IDLE) ? dreq.addr[3 +: IDX_W] : addr_q[3 +: IDX_W];

`ifdef DBUS_RAM_RANGE_CHECK_EN
   assign lat_oor = |addr_q[63:3+IDX_W];
   assign rd_oor  = (state_q == IDLE) ? |dreq.addr[63:3+IDX_W] : lat_oor;
`else
   assign lat_oor = 1'b0;
   assign rd_oor  = 1'b0;
`endif

   assign enter_resp = ((state_q == IDLE) && dreq.valid && (LATENCY == 1)) ||
                       ((state_q == BUSY) && (cnt_q == CNT_W'(1)));
   assign resp_data  = rd_oor ? '0 : rdata;
   assign we         = (state_q == RESP) && (|strobe_q) && !lat_oor;
   assign dresp      = resp_q;

   assign unused_bits = ^{size_q, addr_q[2:0], addr_q[63:3+IDX_W]};

   dbus_ram_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk      (clk),
      .idx_i    (arr_idx),
      .rdata_o  (rdata),
      .we_i     (we),
      .strobe_i (strobe_q),
      .wdata_i  (data_q)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         size_q   <= '0;
         strobe_q <= '0;
         data_q   <= '0;
         resp_q   <= '0;
      end else begin
         resp_q <= '0;
         if (enter_resp) begin
            resp_q.addr_ok <= 1'b1;
            resp_q.data_ok <= 1'b1;
            resp_q.data    <= resp_data;
         end
         case (state_q)
            IDLE: begin
               if (dreq.valid) begin
                  addr_q   <= dreq.addr;
                  size_q   <= dreq.size;
                  strobe_q <= dreq.strobe;
                  data_q   <= dreq.data;
                  if (LATENCY == 1) begin
                     state_q <= RESP;
                  end else begin
                     cnt_q   <= CNT_W'(LATENCY - 1);
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (cnt_q == CNT_W'(1)) state_q <= RESP;
               else                    cnt_q   <= cnt_q - CNT_W'(1);
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef DBUS_RAM_RANGE_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                  err_q <= 1'b0;
      else if (enter_resp && rd_oor) err_q <= 1'b1;
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_dbus_ram_responder.sv
// tb/tb_dbus_ram_responder.sv - scoreboard bench: LATENCY=1/DEPTH=4096 and LATENCY=4/DEPTH=16 instances
module tb_dbus_ram_responder;
   import dbus_ram_responder_pkg::*;

   typedef struct {
      logic [63:0] data;
      bit          care;
   } exp_t;

   logic       clk;
   logic       resetn;
   dbus_req_t  req  [2];
   dbus_resp_t resp [2];
`ifdef DBUS_RAM_RANGE_CHECK_EN
   logic       err_a;
   logic       err_b;
`endif

   int   n_checks;
   int   n_errors;
   exp_t q0 [$];
   exp_t q1 [$];
   bit   prev0;
   bit   prev1;

   dbus_ram_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) dut_a (
      .clk    (clk),
      .resetn (resetn),
      .dreq   (req[0]),
      .dresp  (resp[0])
`ifdef DBUS_RAM_RANGE_CHECK_EN
      ,
      .err    (err_a)
`endif
   );

   dbus_ram_responder #(.DEPTH_WORDS(16), .LATENCY(4)) dut_b (
      .clk    (clk),
      .resetn (resetn),
      .dreq   (req[1]),
      .dresp  (resp[1])
`ifdef DBUS_RAM_RANGE_CHECK_EN
      ,
      .err    (err_b)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (resp[0].data_ok) begin
         check("a_addr_ok_with_data_ok", 64'(resp[0].addr_ok), 64'd1);
         check("a_data_ok_single_cycle", 64'(prev0), 64'd0);
         check("a_response_expected", 64'(q0.size() != 0), 64'd1);
         if (q0.size() != 0) begin
            exp_t e;
            e = q0.pop_front();
            if (e.care) check("a_rdata", resp[0].data, e.data);
         end
      end
      prev0 = resp[0].data_ok;
   end

   always @(negedge clk) begin
      if (resp[1].data_ok) begin
         check("b_addr_ok_with_data_ok", 64'(resp[1].addr_ok), 64'd1);
         check("b_data_ok_single_cycle", 64'(prev1), 64'd0);
         check("b_response_expected", 64'(q1.size() != 0), 64'd1);
         if (q1.size() != 0) begin
            exp_t e;
            e = q1.pop_front();
            if (e.care) check("b_rdata", resp[1].data, e.data);
         end
      end
      prev1 = resp[1].data_ok;
   end

   // Called at a negedge; hold=0 drops valid right after the accept edge, keep=1 leaves the
   // port driven so the next call issues a back-to-back request.
   task automatic do_txn(input int d, input logic [63:0] addr, input logic [7:0] strb,
                         input logic [63:0] wdata, input logic [63:0] exp_data, input bit care,
                         input int exp_cyc, input bit hold, input bit keep);
      exp_t e;
      int   n;
      bit   seen;
      e.data = exp_data;
      e.care = care;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      req[d] = '{valid: 1'b1, addr: addr, size: 3'd3, strobe: strb, data: wdata};
      n    = 0;
      seen = 0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (!hold && n == 1) req[d].valid = 1'b0;
         if (resp[d].data_ok) seen = 1;
         else check("addr_ok_low_before_resp", 64'(resp[d].addr_ok), 64'd0);
      end
      check("response_seen", 64'(seen), 64'd1);
      check("latency_cycles", 64'(n), 64'(exp_cyc));
      if (!keep) begin
         req[d].valid = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      prev0    = 0;
      prev1    = 0;
      resetn   = 1'b0;
      req[0]   = '0;
      req[1]   = '0;
      repeat (2) @(negedge clk);
      check("reset_a_dresp", 64'(resp[0] != '0), 64'd0);
      check("reset_b_dresp", 64'(resp[1] != '0), 64'd0);
`ifdef DBUS_RAM_RANGE_CHECK_EN
      check("reset_err", 64'(err_a | err_b), 64'd0);
`endif
      resetn = 1'b1;
      @(negedge clk);

      // LATENCY=1: full write, read back, partial write, addr[2:0] ignored, read-before-write
      do_txn(0, 64'h10, 8'hFF, 64'h1122334455667788, 64'h0, 0, 1, 1, 0);
      do_txn(0, 64'h10, 8'h00, 64'h0, 64'h1122334455667788, 1, 1, 1, 0);
      do_txn(0, 64'h10, 8'h0F, 64'hAAAAAAAABBBBBBBB, 64'h1122334455667788, 1, 1, 1, 0);
      do_txn(0, 64'h10, 8'h00, 64'h0, 64'h11223344BBBBBBBB, 1, 1, 1, 0);
      do_txn(0, 64'h14, 8'h00, 64'h0, 64'h11223344BBBBBBBB, 1, 1, 1, 0);
      do_txn(0, 64'h18, 8'hFF, 64'h3, 64'h0, 0, 1, 1, 0);
      do_txn(0, 64'h18, 8'hFF, 64'h5, 64'h3, 1, 1, 1, 0);
      do_txn(0, 64'h18, 8'h00, 64'h0, 64'h5, 1, 1, 1, 0);
      do_txn(0, 64'h28, 8'hFF, 64'h0, 64'h0, 0, 1, 1, 0);
      do_txn(0, 64'h28, 8'h81, 64'hABFFFFFFFFFFFFCD, 64'h0, 1, 1, 1, 0);
      do_txn(0, 64'h28, 8'h00, 64'h0, 64'hAB000000000000CD, 1, 1, 1, 0);
      do_txn(0, 64'h10, 8'h00, 64'h0, 64'h11223344BBBBBBBB, 1, 1, 1, 1);
      do_txn(0, 64'h18, 8'h00, 64'h0, 64'h5, 1, 2, 1, 0);

      // LATENCY=4: latency, back-to-back, valid dropped mid-transaction
      do_txn(1, 64'h20, 8'hFF, 64'h0, 64'h0, 0, 4, 1, 0);
      do_txn(1, 64'h20, 8'h00, 64'h0, 64'h0, 1, 4, 1, 1);
      do_txn(1, 64'h20, 8'h00, 64'h0, 64'h0, 1, 5, 1, 0);
      do_txn(1, 64'h30, 8'hFF, 64'hDEADBEEF00C0FFEE, 64'h0, 0, 4, 0, 0);
      do_txn(1, 64'h30, 8'h00, 64'h0, 64'hDEADBEEF00C0FFEE, 1, 4, 1, 0);

      // DEPTH_WORDS=16: 0x80 aliases word 0 unless range checking drops it
      do_txn(1, 64'h00, 8'hFF, 64'h0, 64'h0, 0, 4, 1, 0);
      do_txn(1, 64'h80, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 1, 4, 1, 0);
`ifdef DBUS_RAM_RANGE_CHECK_EN
      do_txn(1, 64'h00, 8'h00, 64'h0, 64'h0, 1, 4, 1, 0);
      do_txn(1, 64'h80, 8'h00, 64'h0, 64'h0, 1, 4, 1, 0);
      check("err_sticky_b", 64'(err_b), 64'd1);
      check("err_clear_a", 64'(err_a), 64'd0);
`else
      do_txn(1, 64'h00, 8'h00, 64'h0, 64'h0123456789ABCDEF, 1, 4, 1, 0);
      do_txn(1, 64'h80, 8'h00, 64'h0, 64'h0123456789ABCDEF, 1, 4, 1, 0);
`endif

      // Reset while BUSY on a write: aborted, write discarded
      req[1] = '{valid: 1'b1, addr: 64'h20, size: 3'd3, strobe: 8'hFF, data: 64'hFFFFFFFFFFFFFFFF};
      repeat (2) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("reset_mid_busy_dresp", 64'(resp[1] != '0), 64'd0);
`ifdef DBUS_RAM_RANGE_CHECK_EN
      check("reset_clears_err", 64'(err_b), 64'd0);
`endif
      req[1].valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      do_txn(1, 64'h20, 8'h00, 64'h0, 64'h0, 1, 4, 1, 0);

      repeat (3) @(negedge clk);
      check("a_queue_drained", 64'(q0.size()), 64'd0);
      check("b_queue_drained", 64'(q1.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
